// File: rtl/keypad_event_encoder_if.sv
// Key event handshake between the keypad encoder and the calculator core.
// The producer drives the head event; the consumer drives evt_ready.
interface keypad_event_encoder_if #(
    parameter int CODE_W = 4
);
    logic              evt_valid;
    logic              evt_ready;
    logic [CODE_W-1:0] evt_code;
    logic              evt_shift;

    modport master (
        output evt_valid,
        output evt_code,
        output evt_shift,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        input  evt_shift,
        output evt_ready
    );
endinterface

// File: rtl/keypad_event_encoder.sv
// Keypad front end: synchronise and debounce digit and shift switches,
// encode presses with a one-shot shift modifier, queue them in a FIFO.
module keypad_event_encoder #(
    parameter int NUM_KEYS        = 10,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4,
    localparam int CODE_W = $clog2(NUM_KEYS),
    localparam int PTR_W  = $clog2(FIFO_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_in,
    input  logic                shift_in,
    keypad_event_encoder_if.master evt,
    output logic [PTR_W:0]      fifo_count,
    output logic                shift_armed,
    output logic                overflow
);

    localparam int NIN   = NUM_KEYS + 1;
    localparam int CNT_W =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX =
        CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PTR_W:0] FULL_CNT =
        (PTR_W + 1)'(FIFO_DEPTH);

    // Bit NUM_KEYS of every input vector is the shift switch.
    logic [NIN-1:0]   sync1_q;
    logic [NIN-1:0]   sync2_q;
    logic [NIN-1:0]   db_q;
    logic [NIN-1:0]   db_d;
    logic [NIN-1:0]   rise;
    logic [CNT_W-1:0] cnt_q [NIN];
    logic [CNT_W-1:0] cnt_d [NIN];

    logic              armed_q;
    logic              armed_d;
    logic              armed_t;
    logic              dig_hit;
    logic [CODE_W-1:0] dig_code;

    logic [CODE_W-1:0] mem_code_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_shift_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_d;
    logic [PTR_W:0]    count_q;
    logic [PTR_W:0]    count_d;
    logic              ovf_q;
    logic              ovf_d;
    logic              valid;
    logic              full;
    logic              pop;
    logic              push;
    logic              push_ok;
    logic              evt_shift_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {shift_in, key_in};
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        db_d = db_q;
        for (int i = 0; i < NIN; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        rise = db_d & ~db_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db_q <= '0;
            for (int i = 0; i < NIN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            db_q <= db_d;
            for (int i = 0; i < NIN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Lowest index wins when several digits rise together.
    always_comb begin
        dig_hit  = 1'b0;
        dig_code = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (rise[i]) begin
                dig_hit  = 1'b1;
                dig_code = CODE_W'(i);
            end
        end
    end

    always_comb begin
        armed_t      = armed_q ^ rise[NUM_KEYS];
        armed_d      = dig_hit ? 1'b0 : armed_t;
        evt_shift_in = armed_t;
    end

    assign valid   = (count_q != '0);
    assign full    = (count_q == FULL_CNT);
    assign pop     = valid & evt.evt_ready;
    assign push    = dig_hit;
    assign push_ok = push & (~full | pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (push & ~push_ok) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            armed_q  <= armed_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: the head is masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_code_q[wr_ptr_q]  <= dig_code;
            mem_shift_q[wr_ptr_q] <= evt_shift_in;
        end
    end

    assign evt.evt_valid = valid;
    assign evt.evt_code  = valid ? mem_code_q[rd_ptr_q] : '0;
    assign evt.evt_shift = valid & mem_shift_q[rd_ptr_q];
    assign fifo_count    = count_q;
    assign shift_armed   = armed_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_keypad_event_encoder.sv
// Scoreboard bench for keypad_event_encoder: expected events are queued
// when presses are driven and compared as the core side accepts them.
module tb_keypad_event_encoder;

    localparam int NK = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] key_in = '0;
    logic          shift_in = 1'b0;
    logic [2:0]    fifo_count;
    logic          shift_armed;
    logic          overflow;

    keypad_event_encoder_if #(.CODE_W(4)) evt_if ();

    keypad_event_encoder #(
        .NUM_KEYS(NK),
        .DEBOUNCE_CYCLES(4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_in(key_in),
        .shift_in(shift_in),
        .evt(evt_if),
        .fifo_count(fifo_count),
        .shift_armed(shift_armed),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int evt_seen = 0;
    int exp_q [$];

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected entry encoding: code*2 + shift.
    task automatic expect_evt(input int code, input int sh);
        exp_q.push_back(code * 2 + sh);
    endtask

    always @(negedge clk) begin
        if (!rst && evt_if.evt_valid && evt_if.evt_ready) begin
            evt_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_evt", 1, 0);
            end else begin
                int e;
                e = exp_q.pop_front();
                chk("evt_code", int'(evt_if.evt_code), e / 2);
                chk("evt_shift", int'(evt_if.evt_shift), e % 2);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // k < 0 selects the shift switch.
    task automatic tap(input int k, input int hold);
        if (k < 0) shift_in = 1'b1;
        else key_in[k] = 1'b1;
        idle(hold);
        key_in   = '0;
        shift_in = 1'b0;
        idle(10);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (evt_if.evt_valid) break;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, int'(evt_if.evt_valid), 0);
        chk({tag, "_code"}, int'(evt_if.evt_code), 0);
        chk({tag, "_shift"}, int'(evt_if.evt_shift), 0);
        chk({tag, "_count"}, int'(fifo_count), 0);
        chk({tag, "_armed"}, int'(shift_armed), 0);
        chk({tag, "_ovf"}, int'(overflow), 0);
    endtask

    initial begin
        int lat;
        int seen0;
        evt_if.evt_ready = 1'b1;
        idle(3);
        chk_zero("reset");
        rst = 1'b0;
        idle(2);

        // Single press with latency and pulse width
        expect_evt(8, 0);
        key_in[8] = 1'b1;
        wait_valid(lat);
        chk("press_latency", lat, 6);
        @(negedge clk);
        chk("pulse_width", int'(evt_if.evt_valid), 0);
        idle(3);
        key_in = '0;
        idle(12);
        chk("no_release_evt", evt_seen, 1);

        // Glitch
        seen0 = evt_seen;
        key_in[5] = 1'b1;
        idle(3);
        key_in = '0;
        idle(12);
        chk("glitch_count", int'(fifo_count), 0);
        chk("glitch_evt", evt_seen, seen0);

        // Shift one-shot
        tap(-1, 10);
        chk("shift_armed_set", int'(shift_armed), 1);
        expect_evt(3, 1);
        tap(3, 8);
        chk("shift_consumed", int'(shift_armed), 0);
        tap(-1, 8);
        tap(-1, 8);
        chk("shift_twice", int'(shift_armed), 0);
        expect_evt(2, 0);
        tap(2, 8);

        // Full FIFO with overflow
        evt_if.evt_ready = 1'b0;
        tap(2, 8);
        tap(5, 8);
        tap(3, 8);
        tap(3, 8);
        tap(4, 8);
        chk("full_count", int'(fifo_count), 4);
        chk("overflow_set", int'(overflow), 1);
        expect_evt(2, 0);
        expect_evt(5, 0);
        expect_evt(3, 0);
        expect_evt(3, 0);
        evt_if.evt_ready = 1'b1;
        idle(10);
        chk("drained_count", int'(fifo_count), 0);
        chk("overflow_sticky", int'(overflow), 1);

        // Collisions
        seen0 = evt_seen;
        expect_evt(1, 0);
        key_in[1] = 1'b1;
        key_in[7] = 1'b1;
        idle(8);
        key_in = '0;
        idle(12);
        chk("collide_one_evt", evt_seen, seen0 + 1);
        expect_evt(9, 1);
        tap(-1, 0);
        shift_in  = 1'b1;
        key_in[9] = 1'b1;
        idle(8);
        key_in   = '0;
        shift_in = 1'b0;
        idle(12);
        chk("collide_armed", int'(shift_armed), 0);

        // Reset mid-operation with queued events
        evt_if.evt_ready = 1'b0;
        tap(0, 8);
        tap(1, 8);
        chk("queued_two", int'(fifo_count), 2);
        key_in[4] = 1'b1;
        idle(3);
        rst = 1'b1;
        idle(1);
        chk_zero("mid_rst");
        key_in = '0;
        idle(3);
        rst = 1'b0;
        idle(12);
        chk("post_rst_count", int'(fifo_count), 0);
        evt_if.evt_ready = 1'b1;

        // Key held through reset release
        key_in[6] = 1'b1;
        rst = 1'b1;
        idle(3);
        expect_evt(6, 0);
        rst = 1'b0;
        wait_valid(lat);
        chk("held_latency", lat, 6);
        key_in = '0;
        idle(12);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/keypad_event_encoder.md
# keypad_event_encoder

Parametrised front end for the calculator's push-switch keypad. It synchronises and debounces NUM_KEYS digit switches plus one shift switch, and turns each debounced press into a key event. The shift key acts as a one-shot modifier on the next digit. Events are queued in a small FIFO and drained by the calculator core over a valid/ready handshake, so the core never samples raw switches directly.

## Interface

Parameters:
- NUM_KEYS, default 10: number of digit switches, legal range 2..16. Bit i of key_in is digit i (bit 0 is key 0).
- DEBOUNCE_CYCLES, default 4: number of consecutive stable samples needed to accept a level change; must be ≥1.
- FIFO_DEPTH, default 4: event queue depth; must be a power of 2 and ≥2.
- CODE_W is derived as ceil(log2(NUM_KEYS)); it is not user-settable.

Ports:
- clk, in, 1: single clock; all logic is on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- key_in, in, NUM_KEYS: raw, asynchronous digit switch levels; 1 means pressed.
- shift_in, in, 1: raw, asynchronous shift switch level.
- evt_valid, out, 1: the FIFO head holds an event.
- evt_ready, in, 1: the consumer accepts the head event.
- evt_code, out, CODE_W: digit index of the head event.
- evt_shift, out, 1: the head event carries the shift modifier.
- fifo_count, out, log2(FIFO_DEPTH)+1: number of queued events.
- shift_armed, out, 1: shift modifier pending; also drives the shift LED.
- overflow, out, 1: sticky flag; set when an event is dropped because the FIFO is full.

## Operation

Input path:
- Every raw input passes through a 2-flop synchronizer (reset value 0), giving a synchronized sample s.
- Each input has its own debounce: a debounced level db and a counter cnt.
  - If s == db, cnt clears to 0.
  - If s != db and cnt == DEBOUNCE_CYCLES-1, db takes the value of s and cnt clears.
  - Otherwise cnt increments.
- A press is a 0→1 transition of db. Releases produce no event.

Shift handling:
- A shift press toggles shift_armed.
- A digit press takes evt_shift = shift_armed, then clears shift_armed.
- When a shift press and a digit press occur in the same cycle, the toggle is applied first and the digit sees the toggled value.
  - Example: shift_armed = 0 → digit is shifted.
  - Example: shift_armed = 1 → digit is unshifted.
  - In both cases shift_armed ends at 0.

Simultaneous digit presses:
- When several digit presses occur in one cycle, only the lowest index is enqueued.
- The other presses are discarded. Their keys stay pressed in db, so they generate no later event until they are released and pressed again.

FIFO:
- Show-ahead FIFO: the head entry is presented whenever evt_valid = 1.
- Pop occurs when evt_valid & evt_ready.
- When evt_valid = 0, evt_code and evt_shift are driven to 0.
- Push when FIFO is full and a pop occurs in the same cycle: the push is accepted and fifo_count stays unchanged.
- Push when FIFO is full with no pop: the event is dropped and overflow is set to 1. shift_armed is still consumed.
- Push and pop on an empty FIFO cannot coincide, because evt_valid is 0.
- Read and write pointers wrap modulo FIFO_DEPTH.

Reset:
- Reset values: all outputs 0; synchronizers, db, cnt, pointers, shift_armed and overflow all 0.
- overflow clears only on rst.
- A reset during debounce or with events queued discards everything.
- A key held through the release of rst is seen as a new press and produces an event after the normal latency.

## Timing

- Press latency: take edge E as the first edge that samples key_in[i] = 1.
  - The synchronized sample is high after edge E+1.
  - db rises and the event is written at edge E+1+DEBOUNCE_CYCLES.
  - evt_valid is high in the following cycle: a total of DEBOUNCE_CYCLES+2 edges.
- Glitches: a high pulse shorter than DEBOUNCE_CYCLES synchronized cycles produces no event.
- shift_armed updates on the same edge on which shift's db rises.
- Handshake: with evt_ready held at 1, a single event gives an evt_valid pulse of exactly 1 cycle.
- Each accepted handshake (evt_valid & evt_ready) removes exactly one entry, on that edge.
- fifo_count changes on the edge of each push or pop; it is unchanged when both occur together.

## Test plan

All scenarios use NUM_KEYS=10, DEBOUNCE_CYCLES=4, FIFO_DEPTH=4.

1. Single press: key_in[8]=1 for 10 cycles, evt_ready=1 → evt_valid high for 1 cycle, 6 edges after first sample, with evt_code=8, evt_shift=0. No event on release.
2. Glitch: key_in[5] high for 3 cycles → no event, fifo_count stays 0.
3. Shift one-shot:
   - shift_in for 10 cycles → shift_armed=1.
   - Then key 3 → event code=3, shift=1, and shift_armed returns to 0.
   - Shift pressed twice, then key 2 → event code=2, shift=0.
4. Full FIFO: evt_ready=0, press 2,5,3,3,4 sequentially → fifo_count=4, overflow=1. Draining yields 2,5,3,3, and overflow stays 1.
5. Collisions:
   - key_in[1] and key_in[7] rise together → exactly one event, code 1.
   - With shift_armed=0, shift and key 9 pressed in the same cycle → event code=9, shift=1, and shift_armed ends at 0.
6. Reset mid-operation:
   - rst asserted during debounce with 2 events queued → all outputs 0 the next cycle, and no event from the interrupted debounce if the key is released during rst.
   - A key held through the release of rst → one event, 6 edges after rst deasserts.
